// File: rtl/regfile_pkg.sv
// Shared constants and address-legality helper for the parametrised register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  // Legal means inside the array and not the hard-wired zero register.
  function automatic logic addrLegal(input int unsigned addr, input int unsigned depth,
                                     input bit zeroReg);
    return (addr < depth) && !(zeroReg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: DEPTH-to-1 select, same-cycle write bypass, zero/out-of-range
// forcing and an optional output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int REG_RD   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wrEn,
  input  logic [ADDR_W-1:0]       wrAddr,
  input  logic [DATA_W-1:0]       wrData,
  input  logic [DEPTH*DATA_W-1:0] memFlat,
  input  logic                    rdEn,
  input  logic [ADDR_W-1:0]       rdAddr,
  output logic [DATA_W-1:0]       rdData,
  output logic                    rdValid
);

  logic [DATA_W-1:0] memSel_s;
  logic [DATA_W-1:0] selVal_s;
  logic              rdLegal_s;

  assign rdLegal_s = addrLegal(32'(rdAddr), DEPTH, ZERO_REG != 0);

  // AND-OR select of the addressed register
  always_comb begin
    memSel_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      memSel_s = memSel_s | (memFlat[i*DATA_W +: DATA_W] & {DATA_W{rdAddr == ADDR_W'(i)}});
    end
  end

  // Priority: forced zero, then bypass of the in-flight write, then stored value
  always_comb begin
    selVal_s = '0;
    if (!rdLegal_s) begin
      selVal_s = '0;
    end else if (wrEn && (wrAddr == rdAddr)) begin
      selVal_s = wrData;
    end else begin
      selVal_s = memSel_s;
    end
  end

  generate
    if (REG_RD != 0) begin : gReg
      logic [DATA_W-1:0] rdData_r;
      logic              rdValid_r;

      // Output register: data holds when idle, valid pulses per request
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdData_r  <= '0;
          rdValid_r <= 1'b0;
        end else if (rdEn) begin
          rdData_r  <= selVal_s;
          rdValid_r <= 1'b1;
        end else begin
          rdValid_r <= 1'b0;
        end
      end

      assign rdData  = rdData_r;
      assign rdValid = rdValid_r;
    end else begin : gComb
      assign rdData  = selVal_s;
      assign rdValid = rdEn;
    end
  endgenerate

endmodule

// File: rtl/regfile_nrd_bypass.sv
// Multi-port register file: storage array and write port, with NUM_RD
// independent bypassing read ports.
module regfile_nrd_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int REG_RD   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  logic [DATA_W-1:0]       mem_r [DEPTH];
  logic [DEPTH*DATA_W-1:0] memFlat_s;
  logic                    wrLegal_s;

  // Dropped writes are masked here so the read ports never bypass them.
  assign wrLegal_s = wr_en && addrLegal(32'(wr_addr), DEPTH, ZERO_REG != 0);

  // Storage array write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wrLegal_s && (wr_addr == ADDR_W'(i))) begin
          mem_r[i] <= wr_data;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : gFlat
      assign memFlat_s[g*DATA_W +: DATA_W] = mem_r[g];
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : gPort
      regfile_rd_port #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .REG_RD  (REG_RD)
      ) uPort (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrEn   (wrLegal_s),
        .wrAddr (wr_addr),
        .wrData (wr_data),
        .memFlat(memFlat_s),
        .rdEn   (rd_en[p]),
        .rdAddr (rd_addr[p*ADDR_W +: ADDR_W]),
        .rdData (rd_data[p*DATA_W +: DATA_W]),
        .rdValid(rd_valid[p])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_nrd_bypass.sv
// Self-checking bench: a registered 3-port, 24-deep zero-register file and a
// combinational 2-port, 32-deep file without zero register, against an array model.
module tb_regfile_nrd_bypass;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [2:0]  rdEn;
  logic [14:0] rdAddr;
  logic [95:0] rdDataA;
  logic [2:0]  rdValidA;
  logic [63:0] rdDataB;
  logic [1:0]  rdValidB;

  int nCmp = 0;
  int nBad = 0;

  bit [31:0] refA [24];
  bit [31:0] refB [32];
  bit [31:0] expDA [3];
  bit        expVA [3];

  always #5 clk = ~clk;

  regfile_nrd_bypass #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .NUM_RD(3),
                       .ZERO_REG(1), .REG_RD(1)) dutA (
    .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_valid(rdValidA));

  regfile_nrd_bypass #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2),
                       .ZERO_REG(0), .REG_RD(0)) dutB (
    .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_en(rdEn[1:0]), .rd_addr(rdAddr[9:0]), .rd_data(rdDataB), .rd_valid(rdValidB));

  // Reference selection rules for each configuration
  function automatic bit [31:0] selA(input bit [4:0] a);
    if (a >= 5'd24 || a == 5'd0) return 32'd0;
    if (wrEn && wrAddr == a) return wrData;
    return refA[a];
  endfunction

  function automatic bit [31:0] selB(input bit [4:0] a);
    if (wrEn && wrAddr == a) return wrData;
    return refB[a];
  endfunction

  task automatic clearModel();
    foreach (refA[i]) refA[i] = 32'd0;
    foreach (refB[i]) refB[i] = 32'd0;
    foreach (expDA[i]) expDA[i] = 32'd0;
    foreach (expVA[i]) expVA[i] = 1'b0;
  endtask

  // Advance one clock, updating the model with what the edge should do
  task automatic tick();
    if (!rst_n) begin
      clearModel();
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (rdEn[p]) expDA[p] = selA(rdAddr[p*5 +: 5]);
        expVA[p] = rdEn[p];
      end
      if (wrEn) begin
        if (wrAddr < 5'd24 && wrAddr != 5'd0) refA[wrAddr] = wrData;
        refB[wrAddr] = wrData;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wrEn = 1'b0; wrAddr = 5'd0; wrData = 32'd0; rdEn = 3'd0; rdAddr = 15'd0;
    tick(); tick();
    for (int p = 0; p < 3; p++) begin
      nCmp++;
      if (rdDataA[p*32 +: 32] !== 32'd0 || rdValidA[p] !== 1'b0) begin
        nBad++; $display("FAIL reset_hold p%0d: got %h/%b want 0/0", p, rdDataA[p*32 +: 32], rdValidA[p]);
      end
    end
    rst_n = 1'b1;
    wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'hDEADBEEF; rdEn = 3'b001; rdAddr = {5'd5, 5'd5, 5'd5};
    tick();
    nCmp++;
    if (rdDataA[31:0] !== 32'hDEADBEEF || rdValidA[0] !== 1'b1) begin
      nBad++; $display("FAIL reset_prewrite: got %h/%b want deadbeef/1", rdDataA[31:0], rdValidA[0]);
    end
    rdEn = 3'b111;
    #2 rst_n = 1'b0;
    clearModel();
    #1;
    nCmp++;
    if (rdDataA !== 96'd0 || rdValidA !== 3'd0) begin
      nBad++; $display("FAIL reset_async: got %h/%b want 0/0", rdDataA, rdValidA);
    end
    tick();
    rst_n = 1'b1; wrEn = 1'b0; rdEn = 3'b001;
    #1;
    nCmp++;
    if (rdDataB[31:0] !== 32'd0 || rdValidB[0] !== 1'b1) begin
      nBad++; $display("FAIL reset_readB: got %h/%b want 0/1", rdDataB[31:0], rdValidB[0]);
    end
    tick();
    nCmp++;
    if (rdDataA[31:0] !== 32'd0 || rdValidA[0] !== 1'b1) begin
      nBad++; $display("FAIL reset_readA: got %h/%b want 0/1", rdDataA[31:0], rdValidA[0]);
    end
  endtask

  task automatic test_basic();
    wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'h12345678; rdEn = 3'd0;
    tick();
    wrEn = 1'b0; rdEn = 3'b001; rdAddr[4:0] = 5'd7;
    #1;
    nCmp++;
    if (rdDataB[31:0] !== 32'h12345678 || rdValidB[0] !== 1'b1) begin
      nBad++; $display("FAIL basic_B: got %h/%b want 12345678/1", rdDataB[31:0], rdValidB[0]);
    end
    tick();
    nCmp++;
    if (rdDataA[31:0] !== 32'h12345678 || rdValidA[0] !== 1'b1) begin
      nBad++; $display("FAIL basic_A: got %h/%b want 12345678/1", rdDataA[31:0], rdValidA[0]);
    end
    rdEn = 3'd0;
    tick();
    nCmp++;
    if (rdDataA[31:0] !== 32'h12345678 || rdValidA[0] !== 1'b0 || rdValidB[0] !== 1'b0) begin
      nBad++; $display("FAIL basic_hold: got %h/%b/%b want 12345678/0/0", rdDataA[31:0], rdValidA[0], rdValidB[0]);
    end
  endtask

  task automatic test_bypass();
    wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h1; rdEn = 3'd0;
    tick();
    wrData = 32'hA5A5A5A5; rdEn = 3'b010; rdAddr[9:5] = 5'd9;
    #1;
    nCmp++;
    if (rdDataB[63:32] !== 32'hA5A5A5A5) begin
      nBad++; $display("FAIL bypass_B: got %h want a5a5a5a5", rdDataB[63:32]);
    end
    tick();
    nCmp++;
    if (rdDataA[63:32] !== 32'hA5A5A5A5 || rdValidA[1] !== 1'b1) begin
      nBad++; $display("FAIL bypass_A: got %h/%b want a5a5a5a5/1", rdDataA[63:32], rdValidA[1]);
    end
    wrEn = 1'b0;
  endtask

  task automatic test_zero_reg();
    wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFFFFFF; rdEn = 3'b001; rdAddr[4:0] = 5'd0;
    #1;
    nCmp++;
    if (rdDataB[31:0] !== 32'hFFFFFFFF) begin
      nBad++; $display("FAIL zero_B_bypass: got %h want ffffffff", rdDataB[31:0]);
    end
    tick();
    nCmp++;
    if (rdDataA[31:0] !== 32'd0 || rdValidA[0] !== 1'b1) begin
      nBad++; $display("FAIL zero_A_bypass: got %h/%b want 0/1", rdDataA[31:0], rdValidA[0]);
    end
    wrEn = 1'b0;
    #1;
    nCmp++;
    if (rdDataB[31:0] !== 32'hFFFFFFFF) begin
      nBad++; $display("FAIL zero_B_stored: got %h want ffffffff", rdDataB[31:0]);
    end
    tick();
    nCmp++;
    if (rdDataA[31:0] !== 32'd0) begin
      nBad++; $display("FAIL zero_A_stored: got %h want 0", rdDataA[31:0]);
    end
  endtask

  task automatic test_out_of_range();
    wrEn = 1'b1; wrAddr = 5'd30; wrData = 32'h55; rdEn = 3'd0;
    tick();
    wrEn = 1'b0; rdEn = 3'b001; rdAddr[4:0] = 5'd30;
    #1;
    nCmp++;
    if (rdDataB[31:0] !== 32'h55) begin
      nBad++; $display("FAIL oor_B: got %h want 55", rdDataB[31:0]);
    end
    tick();
    nCmp++;
    if (rdDataA[31:0] !== 32'd0) begin
      nBad++; $display("FAIL oor_A: got %h want 0", rdDataA[31:0]);
    end
    for (int i = 0; i < 24; i++) begin
      rdEn = 3'b100; rdAddr[14:10] = 5'(i);
      tick();
      nCmp++;
      if (rdDataA[95:64] !== expDA[2]) begin
        nBad++; $display("FAIL oor_scan r%0d: got %h want %h", i, rdDataA[95:64], expDA[2]);
      end
    end
  endtask

  task automatic test_multiport_sweep();
    rdEn = 3'd0;
    for (int i = 0; i < 32; i++) begin
      wrEn = 1'b1; wrAddr = 5'(i); wrData = 32'(i) * 32'h01010101;
      tick();
    end
    wrEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rdEn = 3'b111; rdAddr = {5'(31 - i), 5'(i), 5'(i)};
      #1;
      for (int p = 0; p < 2; p++) begin
        nCmp++;
        if (rdDataB[p*32 +: 32] !== selB(rdAddr[p*5 +: 5])) begin
          nBad++; $display("FAIL sweep_B i%0d p%0d: got %h want %h", i, p, rdDataB[p*32 +: 32], selB(rdAddr[p*5 +: 5]));
        end
      end
      tick();
      for (int p = 0; p < 3; p++) begin
        nCmp++;
        if (rdDataA[p*32 +: 32] !== expDA[p] || rdValidA[p] !== expVA[p]) begin
          nBad++; $display("FAIL sweep_A i%0d p%0d: got %h/%b want %h/%b", i, p, rdDataA[p*32 +: 32], rdValidA[p], expDA[p], expVA[p]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wrEn = 1'($urandom_range(0, 1)); wrAddr = 5'($urandom); wrData = $urandom;
      rdEn = 3'($urandom); rdAddr = 15'($urandom);
      if ($urandom_range(0, 3) == 0) rdAddr[4:0] = wrAddr;
      if ($urandom_range(0, 3) == 0) rdAddr[14:10] = wrAddr;
      #1;
      for (int p = 0; p < 2; p++) begin
        nCmp++;
        if (rdDataB[p*32 +: 32] !== selB(rdAddr[p*5 +: 5]) || rdValidB[p] !== rdEn[p]) begin
          nBad++; $display("FAIL random_B n%0d p%0d: got %h/%b want %h/%b", n, p, rdDataB[p*32 +: 32], rdValidB[p], selB(rdAddr[p*5 +: 5]), rdEn[p]);
        end
      end
      tick();
      for (int p = 0; p < 3; p++) begin
        nCmp++;
        if (rdDataA[p*32 +: 32] !== expDA[p] || rdValidA[p] !== expVA[p]) begin
          nBad++; $display("FAIL random_A n%0d p%0d: got %h/%b want %h/%b", n, p, rdDataA[p*32 +: 32], rdValidA[p], expDA[p], expVA[p]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_zero_reg();
    test_out_of_range();
    test_multiport_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
